// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit scheduler
// Purpose: FSM state encoding and byte width used by the scheduler and its interface.
// Ports: none (package).
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4,
    FINISH    = 3'd5
  } state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter handshake bundle for the scheduler
// Purpose: groups both requester ports and the transmitter start/data/ready link.
// Ports (signals):
//   req0/req1    level requests          word0/word1  payloads, sampled at grant
//   done0/done1  completion pulses       busy, grant  transfer status / owner
//   tx_start, tx_data -> transmitter     tx_ready <- transmitter
// Modports: slave = scheduler side, master = requester/transmitter side.
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 4
);

  logic                         req0;
  logic [BYTE_W*WORD_BYTES-1:0] word0;
  logic                         req1;
  logic [BYTE_W*WORD_BYTES-1:0] word1;
  logic                         done0;
  logic                         done1;
  logic                         busy;
  logic                         grant;
  logic                         tx_start;
  logic [BYTE_W-1:0]            tx_data;
  logic                         tx_ready;

  modport slave (
    input  req0, word0, req1, word1, tx_ready,
    output done0, done1, busy, grant, tx_start, tx_data
  );

  modport master (
    output req0, word0, req1, word1, tx_ready,
    input  done0, done1, busy, grant, tx_start, tx_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with last-grant memory
// Purpose: combinational choice between two requesters; the last-grant register
//          updates only when the choice is actually taken (en_i).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en_i              commit current choice as the new last grant
//   req0_i, req1_i    requests
//   gnt_o             chosen requester (0 or 1), valid when any request is high
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 1'b0;
    // On a tie the requester that did not win last time goes next.
    if (req0_i && req1_i) begin
      gnt_o = ~last_q;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end
    last_d = en_i ? gnt_o : last_q;
  end

  // Last grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin two-requester front end for a byte UART transmitter
// Purpose: grants the transmitter to one requester, latches its word and sends it
//          MSB byte first over the start/data/ready handshake, pulsing done per requester.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       uart_tx_scheduler_if.slave: requests/words in, done/busy/grant out,
//             tx_start/tx_data to the transmitter, tx_ready from it
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_scheduler_if.slave    bus
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES) + 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;

  logic                arb_en;
  logic                arb_gnt;
  logic [WORD_W-1:0]   sel_word;
  logic [WORD_W-1:0]   shifted;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en_i   (arb_en),
    .req0_i (bus.req0),
    .req1_i (bus.req1),
    .gnt_o  (arb_gnt)
  );

  assign sel_word = arb_gnt ? bus.word1 : bus.word0;
  assign shifted  = shift_q << BYTE_W;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = busy_q;
    grant_d    = grant_q;
    arb_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_ready && (bus.req0 || bus.req1)) begin
          arb_en     = 1'b1;
          shift_d    = sel_word;
          cnt_d      = CNT_W'(WORD_BYTES - 1);
          grant_d    = arb_gnt;
          busy_d     = 1'b1;
          // Registered outputs: start and the MSB byte appear in the START cycle.
          tx_start_d = 1'b1;
          tx_data_d  = sel_word[WORD_W-1 -: BYTE_W];
          state_d    = START;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Ready may stay high until the transmitter's next baud tick.
        if (!bus.tx_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (cnt_q == '0) begin
            done0_d = ~grant_q;
            done1_d = grant_q;
            state_d = FINISH;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        shift_d    = shifted;
        cnt_d      = cnt_q - CNT_W'(1);
        tx_start_d = 1'b1;
        tx_data_d  = shifted[WORD_W-1 -: BYTE_W];
        state_d    = START;
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.busy     = busy_q;
  assign bus.grant    = grant_q;

endmodule
